wb_bus_guard: RTL and testbench

- Wishbone classic-cycle guard between the NEORV32 external bus master and the TwPM address decoder (TPM regs/RAM, LiteDRAM data and controller ports).
- Forwards each request downstream and registers the slave response back to the CPU.
- If no slave responds within a bounded time, it terminates the access with an error, so a dead or unmapped slave cannot hang the CPU.
- Records the faulting access and raises a one-cycle interrupt pulse.

---
 rtl/twpm_wb_pkg.sv | 18 +
 rtl/wb_bus_guard.sv | 168 ++++++++++++++++
 tb/tb_wb_bus_guard.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/twpm_wb_pkg.sv
// Shared Wishbone definitions for the TwPM bus fabric: bus widths, the guard
// state encoding and the read value returned for unmapped or faulted reads.
package twpm_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Also returned by the TPM register read mux for unmapped offsets.
    localparam logic [WB_DAT_W-1:0] DEFAULT_READ_VALUE = 32'hBADFABAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } guard_state_t;

endpackage

// File: rtl/wb_bus_guard.sv
// Wishbone classic-cycle guard between the CPU bus master and the address decoder.
// Registers slave responses and ends any access no slave answers with an error.
module wb_bus_guard
    import twpm_wb_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES  = 255,
    parameter int                    CNT_WIDTH       = 8,
    parameter logic [WB_DAT_W-1:0]   ERR_READ_VALUE  = DEFAULT_READ_VALUE,
    parameter int                    FAULT_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic [WB_ADR_W-1:0]        m_adr_i,
    input  logic [WB_DAT_W-1:0]        m_dat_i,
    input  logic                       m_we_i,
    input  logic [WB_SEL_W-1:0]        m_sel_i,
    input  logic                       m_stb_i,
    input  logic                       m_cyc_i,
    output logic [WB_DAT_W-1:0]        m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,

    output logic [WB_ADR_W-1:0]        s_adr_o,
    output logic [WB_DAT_W-1:0]        s_dat_o,
    output logic                       s_we_o,
    output logic [WB_SEL_W-1:0]        s_sel_o,
    output logic                       s_stb_o,
    output logic                       s_cyc_o,
    input  logic [WB_DAT_W-1:0]        s_dat_i,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,

    input  logic                       clr_i,
    output logic [WB_ADR_W-1:0]        fault_addr_o,
    output logic                       fault_we_o,
    output logic                       fault_valid_o,
    output logic [FAULT_CNT_WIDTH-1:0] fault_cnt_o,
    output logic                       fault_irq_o
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    guard_state_t               state;
    guard_state_t               state_next;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [CNT_WIDTH-1:0]       cnt_next;
    logic [WB_DAT_W-1:0]        dat_next;
    logic                       ack_next;
    logic                       err_next;
    logic [WB_ADR_W-1:0]        fault_addr_next;
    logic                       fault_we_next;
    logic                       fault_valid_next;
    logic [FAULT_CNT_WIDTH-1:0] fault_cnt_next;
    logic                       fault_irq_next;
    logic                       req;
    logic                       in_resp;

    assign req     = m_cyc_i & m_stb_i;
    assign in_resp = (state == RESP);

    // Dropping cyc/stb during the response cycle ends a stalled slave cycle
    // and keeps the same request from being issued twice.
    assign s_adr_o = m_adr_i;
    assign s_dat_o = m_dat_i;
    assign s_we_o  = m_we_i;
    assign s_sel_o = m_sel_i;
    assign s_cyc_o = m_cyc_i & ~in_resp;
    assign s_stb_o = m_stb_i & m_cyc_i & ~in_resp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            m_dat_o       <= '0;
            m_ack_o       <= 1'b0;
            m_err_o       <= 1'b0;
            fault_addr_o  <= '0;
            fault_we_o    <= 1'b0;
            fault_valid_o <= 1'b0;
            fault_cnt_o   <= '0;
            fault_irq_o   <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            m_dat_o       <= dat_next;
            m_ack_o       <= ack_next;
            m_err_o       <= err_next;
            fault_addr_o  <= fault_addr_next;
            fault_we_o    <= fault_we_next;
            fault_valid_o <= fault_valid_next;
            fault_cnt_o   <= fault_cnt_next;
            fault_irq_o   <= fault_irq_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        dat_next         = m_dat_o;
        ack_next         = 1'b0;
        err_next         = 1'b0;
        fault_addr_next  = fault_addr_o;
        fault_we_next    = fault_we_o;
        fault_valid_next = fault_valid_o;
        fault_cnt_next   = fault_cnt_o;
        fault_irq_next   = 1'b0;

        // A clear is applied first so a timeout in the same cycle counts on top of it.
        if (clr_i) begin
            fault_cnt_next   = '0;
            fault_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (req) begin
                    if (s_err_i) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else if (s_ack_i) begin
                        ack_next   = 1'b1;
                        dat_next   = s_dat_i;
                        state_next = RESP;
                    end else begin
                        cnt_next   = '0;
                        state_next = BUSY;
                    end
                end
            end

            BUSY: begin
                if (!m_cyc_i) begin
                    state_next = IDLE;
                end else if (s_err_i) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end else if (s_ack_i) begin
                    ack_next   = 1'b1;
                    dat_next   = s_dat_i;
                    state_next = RESP;
                end else if (cnt == TIMEOUT_LAST) begin
                    err_next         = 1'b1;
                    dat_next         = ERR_READ_VALUE;
                    state_next       = RESP;
                    fault_addr_next  = m_adr_i;
                    fault_we_next    = m_we_i;
                    fault_valid_next = 1'b1;
                    fault_irq_next   = 1'b1;
                    if (fault_cnt_next != {FAULT_CNT_WIDTH{1'b1}}) begin
                        fault_cnt_next = fault_cnt_next + FAULT_CNT_WIDTH'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_WIDTH'(1);
                end
            end

            RESP: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_bus_guard.sv
// Directed bench for wb_bus_guard with a 16-cycle timeout and a 3-bit fault
// counter so saturation is reachable in a short run.
module tb_wb_bus_guard;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr;
    logic [31:0] m_dat_w;
    logic        m_we;
    logic [3:0]  m_sel;
    logic        m_stb;
    logic        m_cyc;
    logic [31:0] m_dat_r;
    logic        m_ack;
    logic        m_err;
    logic [31:0] s_adr;
    logic [31:0] s_dat_w;
    logic        s_we;
    logic [3:0]  s_sel;
    logic        s_stb;
    logic        s_cyc;
    logic [31:0] s_dat_r;
    logic        s_ack;
    logic        s_err;
    logic        clr;
    logic [31:0] fault_addr;
    logic        fault_we;
    logic        fault_valid;
    logic [2:0]  fault_cnt;
    logic        fault_irq;

    int vectorCount = 0;
    int missCount   = 0;

    always #5 clk = ~clk;

    wb_bus_guard #(
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (8),
        .ERR_READ_VALUE (32'hBADFABAC),
        .FAULT_CNT_WIDTH(3)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .m_adr_i      (m_adr),
        .m_dat_i      (m_dat_w),
        .m_we_i       (m_we),
        .m_sel_i      (m_sel),
        .m_stb_i      (m_stb),
        .m_cyc_i      (m_cyc),
        .m_dat_o      (m_dat_r),
        .m_ack_o      (m_ack),
        .m_err_o      (m_err),
        .s_adr_o      (s_adr),
        .s_dat_o      (s_dat_w),
        .s_we_o       (s_we),
        .s_sel_o      (s_sel),
        .s_stb_o      (s_stb),
        .s_cyc_o      (s_cyc),
        .s_dat_i      (s_dat_r),
        .s_ack_i      (s_ack),
        .s_err_i      (s_err),
        .clr_i        (clr),
        .fault_addr_o (fault_addr),
        .fault_we_o   (fault_we),
        .fault_valid_o(fault_valid),
        .fault_cnt_o  (fault_cnt),
        .fault_irq_o  (fault_irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] adr, input logic we, input logic [31:0] wdat);
        m_adr   = adr;
        m_we    = we;
        m_dat_w = wdat;
        m_sel   = 4'hF;
        m_cyc   = 1'b1;
        m_stb   = 1'b1;
    endtask

    task automatic endRequest();
        m_cyc = 1'b0;
        m_stb = 1'b0;
        s_ack = 1'b0;
        s_err = 1'b0;
    endtask

    // Full timeout transaction: request, no slave answer, error after TO+1 cycles.
    task automatic doTimeout(input logic [31:0] adr);
        applyStimulus(adr, 1'b0, 32'h0);
        step(TO + 1);
        checkOutput("rep_timeout_err", 32'(m_err), 32'd1);
        endRequest();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        m_adr = '0; m_dat_w = '0; m_we = 1'b0; m_sel = '0; m_stb = 1'b0; m_cyc = 1'b0;
        s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0;
        step(2);
        checkOutput("rst_ack",        32'(m_ack),       32'd0);
        checkOutput("rst_err",        32'(m_err),       32'd0);
        checkOutput("rst_dat",        m_dat_r,          32'd0);
        checkOutput("rst_fault_addr", fault_addr,       32'd0);
        checkOutput("rst_fault_cnt",  32'(fault_cnt),   32'd0);
        checkOutput("rst_fault_vld",  32'(fault_valid), 32'd0);
        checkOutput("rst_irq",        32'(fault_irq),   32'd0);
        rst = 1'b0;
        step();

        // Read acked two cycles after strobe.
        applyStimulus(32'hF0000004, 1'b0, 32'h0);
        step();
        checkOutput("rd_stb_fwd", 32'(s_stb), 32'd1);
        checkOutput("rd_no_ack_yet", 32'(m_ack), 32'd0);
        step();
        s_ack = 1'b1;
        s_dat_r = 32'h00000003;
        step();
        checkOutput("rd_ack",     32'(m_ack), 32'd1);
        checkOutput("rd_dat",     m_dat_r,    32'h00000003);
        checkOutput("rd_err",     32'(m_err), 32'd0);
        checkOutput("rd_cyc_gated", 32'(s_cyc), 32'd0);
        step();
        checkOutput("rd_ack_one_cycle", 32'(m_ack), 32'd0);
        endRequest();
        checkOutput("rd_no_fault", 32'(fault_valid), 32'd0);

        // Read to a dead slave times out.
        step();
        applyStimulus(32'h90000000, 1'b0, 32'h0);
        step(TO);
        checkOutput("to_no_err_early", 32'(m_err), 32'd0);
        step();
        checkOutput("to_err",        32'(m_err),     32'd1);
        checkOutput("to_ack",        32'(m_ack),     32'd0);
        checkOutput("to_dat",        m_dat_r,        32'hBADFABAC);
        checkOutput("to_s_cyc",      32'(s_cyc),     32'd0);
        checkOutput("to_fault_addr", fault_addr,     32'h90000000);
        checkOutput("to_fault_we",   32'(fault_we),  32'd0);
        checkOutput("to_irq",        32'(fault_irq), 32'd1);
        checkOutput("to_fault_cnt",  32'(fault_cnt), 32'd1);
        checkOutput("to_fault_vld",  32'(fault_valid), 32'd1);
        endRequest();
        step();
        checkOutput("to_irq_pulse", 32'(fault_irq), 32'd0);
        checkOutput("to_err_clear", 32'(m_err),     32'd0);
        checkOutput("to_dat_hold",  m_dat_r,        32'hBADFABAC);

        // Ack in the very cycle the timeout would fire.
        applyStimulus(32'h90000010, 1'b0, 32'h0);
        step(TO);
        s_ack = 1'b1;
        s_dat_r = 32'h12345678;
        step();
        checkOutput("late_ack",     32'(m_ack),     32'd1);
        checkOutput("late_err",     32'(m_err),     32'd0);
        checkOutput("late_dat",     m_dat_r,        32'h12345678);
        checkOutput("late_irq",     32'(fault_irq), 32'd0);
        checkOutput("late_cnt",     32'(fault_cnt), 32'd1);
        endRequest();
        step();

        // Simultaneous ack and err: err wins, read data untouched.
        applyStimulus(32'hF0000008, 1'b0, 32'h0);
        step();
        s_ack = 1'b1;
        s_err = 1'b1;
        s_dat_r = 32'hAAAA5555;
        step();
        checkOutput("both_err", 32'(m_err), 32'd1);
        checkOutput("both_ack", 32'(m_ack), 32'd0);
        checkOutput("both_dat", m_dat_r,    32'h12345678);
        endRequest();
        step();

        // Master abort in BUSY cycle 5, then a stray ack.
        applyStimulus(32'hF0000010, 1'b0, 32'h0);
        step(5);
        endRequest();
        step();
        s_ack = 1'b1;
        checkOutput("abort_no_ack", 32'(m_ack), 32'd0);
        step();
        checkOutput("stray_no_ack", 32'(m_ack), 32'd0);
        checkOutput("stray_no_err", 32'(m_err), 32'd0);
        s_dat_r = 32'h0BEEF001;
        applyStimulus(32'hF0000020, 1'b1, 32'h55AA55AA);
        step();
        checkOutput("after_abort_ack", 32'(m_ack), 32'd1);
        checkOutput("after_abort_err", 32'(m_err), 32'd0);
        endRequest();
        step();

        // Saturate the 3-bit fault counter: 1 so far, six more reach 7, one more holds.
        for (int i = 0; i < 6; i++) doTimeout(32'h90000100 + 32'(i));
        checkOutput("sat_reach", 32'(fault_cnt), 32'd7);
        doTimeout(32'h90000200);
        checkOutput("sat_hold", 32'(fault_cnt), 32'd7);

        // Clear coinciding with a timeout: the timeout is still counted.
        applyStimulus(32'h90000300, 1'b1, 32'h0);
        step(TO);
        clr = 1'b1;
        step();
        clr = 1'b0;
        checkOutput("clr_to_cnt", 32'(fault_cnt),   32'd1);
        checkOutput("clr_to_vld", 32'(fault_valid), 32'd1);
        checkOutput("clr_to_we",  32'(fault_we),    32'd1);
        endRequest();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        checkOutput("clr_cnt",       32'(fault_cnt),   32'd0);
        checkOutput("clr_vld",       32'(fault_valid), 32'd0);
        checkOutput("clr_keep_addr", fault_addr,       32'h90000300);

        // Asynchronous reset in BUSY cycle 8.
        applyStimulus(32'h90000400, 1'b0, 32'h0);
        step(8);
        rst = 1'b1;
        #1;
        checkOutput("arst_dat",        m_dat_r,        32'd0);
        checkOutput("arst_err",        32'(m_err),     32'd0);
        checkOutput("arst_fault_addr", fault_addr,     32'd0);
        checkOutput("arst_fault_we",   32'(fault_we),  32'd0);
        endRequest();
        step(2);
        rst = 1'b0;
        step();
        checkOutput("arst_no_resp", 32'(m_ack | m_err), 32'd0);

        // Zero-wait write after reset.
        applyStimulus(32'hF0000040, 1'b1, 32'hCAFE0001);
        s_ack = 1'b1;
        #1;
        checkOutput("zw_stb",   32'(s_stb), 32'd1);
        checkOutput("zw_adr",   s_adr,      32'hF0000040);
        checkOutput("zw_wdat",  s_dat_w,    32'hCAFE0001);
        checkOutput("zw_we",    32'(s_we),  32'd1);
        checkOutput("zw_sel",   32'(s_sel), 32'hF);
        step();
        checkOutput("zw_ack",   32'(m_ack), 32'd1);
        checkOutput("zw_err",   32'(m_err), 32'd0);
        endRequest();
        step();
        checkOutput("zw_ack_drop", 32'(m_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
